// File: rtl/pc_sequencer.sv
// pc_sequencer: sequential program-counter controller for the MIPS-32 core.
//
// Owns the PC. It fetches one instruction, holds it for the datapath while the
// instruction executes, and then selects the next PC from one of four sources:
// sequential, branch, jump or jump-register. It also counts retired
// instructions and traps jump-register targets that are not word aligned.
//
// Handshake (imem): imem_req is held high with a stable imem_addr for as long
// as the controller sits in FETCH. A cycle with imem_req=1 and imem_ack=1
// transfers imem_rdata. imem_ack in any other cycle is ignored.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   imem_req/addr       fetch request and address (imem_addr == pc_out)
//   imem_ack/rdata      fetch acknowledge and instruction word
//   instr_out/valid     latched instruction and its execute-valid flag
//   stall               datapath holds the current instruction in EXEC
//   branch_taken, imm_ext, jump, jump_index, jr, jr_addr
//                       next-PC controls, sampled only in EXEC
//   pc_out, pc_plus4    current PC and PC+4 (combinational)
//   retired             retired-instruction counter (wraps)
//   misalign            sticky flag for a misaligned JR target
//   state_dbg           current FSM state (BOOT=0, FETCH=1, EXEC=2, TRAP=3)
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] imm_ext,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired,
    output logic        misalign,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        TRAP  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        jr_misaligned;

    assign pc_out    = pc;
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign state_dbg = state;

    // Next-PC selection, priority jr > jump > branch > sequential.
    // The branch add is plain 32-bit arithmetic: the carry is dropped and a
    // negative immediate works through two's complement.
    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = jr_addr;
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + (imm_ext << 2);
        end
    end

    assign jr_misaligned = jr && (jr_addr[1:0] != 2'b00);

    // imem_req and instr_valid are registered alongside the state so they
    // are high exactly in FETCH and EXEC respectively.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_VECTOR;
            instr_out   <= 32'd0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            retired     <= 32'd0;
            misalign    <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr_out   <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        if (jr_misaligned) begin
                            // Abandon the instruction: PC and retired hold.
                            misalign <= 1'b1;
                            state    <= TRAP;
                        end else begin
                            pc       <= next_pc;
                            retired  <= retired + 32'd1;
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                default: begin
                    // TRAP: everything holds until reset.
                    state       <= TRAP;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer. Inputs change on the falling edge,
// outputs are sampled on the falling edge, half a cycle after the rising edge.
module tb_pc_sequencer;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_TRAP  = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        stall;
    logic        branch_taken;
    logic [31:0] imm_ext;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_addr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] retired;
    logic        misalign;
    logic [1:0]  state_dbg;

    pc_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .branch_taken (branch_taken),
        .imm_ext      (imm_ext),
        .jump         (jump),
        .jump_index   (jump_index),
        .jr           (jr),
        .jr_addr      (jr_addr),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
        .retired      (retired),
        .misalign     (misalign),
        .state_dbg    (state_dbg)
    );

    // Instruction memory: each word is a fixed scramble of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h3C5A_0000;
    endfunction
    assign imem_rdata = mem_word(imem_addr);

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_retired;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_ctl();
        stall        = 1'b0;
        branch_taken = 1'b0;
        imm_ext      = 32'd0;
        jump         = 1'b0;
        jump_index   = 26'd0;
        jr           = 1'b0;
        jr_addr      = 32'd0;
    endtask

    // ---------------- driver tasks ----------------
    // Starts in FETCH at exp_pc; acks the fetch, executes with the given
    // controls and checks the resulting PC and retire count.
    task automatic do_instr(input string tag, input logic br, input logic [31:0] imm,
                            input logic j, input logic [25:0] idx,
                            input logic r, input logic [31:0] ra,
                            input logic [31:0] exp_next);
        imem_ack = 1'b1;
        tick();
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        check({tag, "_instr"}, instr_out, mem_word(exp_pc));
        branch_taken = br;
        imm_ext      = imm;
        jump         = j;
        jump_index   = idx;
        jr           = r;
        jr_addr      = ra;
        tick();
        clear_ctl();
        exp_pc = exp_next;
        exp_retired = exp_retired + 32'd1;
        check({tag, "_pc"}, pc_out, exp_pc);
        check({tag, "_addr"}, imem_addr, exp_pc);
        check({tag, "_retired"}, retired, exp_retired);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_pc = 32'd0;
        exp_retired = 32'd0;
    endtask

    int req_cnt;
    int valid_cnt;
    logic instr_steady;
    logic [31:0] held_pc;
    logic [31:0] held_ret;

    initial begin
        clear_ctl();
        imem_ack = 1'b1;
        tick();
        do_reset();

        // Reset state.
        check("rst_state", {30'd0, state_dbg}, {30'd0, ST_BOOT});
        check("rst_pc", pc_out, 32'd0);
        check("rst_instr", instr_out, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);

        // Sequential fetch with zero-wait memory.
        tick();
        for (int i = 0; i < 3; i++) begin
            check("seq_state", {30'd0, state_dbg}, {30'd0, ST_FETCH});
            check("seq_req", {31'd0, imem_req}, 32'd1);
            do_instr("seq", 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, 32'(4 * (i + 1)));
        end
        check("seq_retired3", retired, 32'd3);
        check("seq_pc_plus4", pc_plus4, 32'd16);

        // Branch backward from 0x100: 0x104 + 0xFFFF_FFF0 = 0xF4.
        do_instr("jr_to_100", 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h0000_0100, 32'h0000_0100);
        do_instr("br_back", 1'b1, 32'hFFFF_FFFC, 1'b0, 26'd0, 1'b0, 32'd0, 32'h0000_00F4);

        // Jump beats branch.
        do_instr("jr_to_1000", 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h1000_0010, 32'h1000_0010);
        do_instr("jump_pri", 1'b1, 32'h0000_0040, 1'b1, 26'h0000040, 1'b0, 32'd0, 32'h1000_0100);

        // jr beats jump and branch.
        do_instr("jr_pri", 1'b1, 32'h0000_0040, 1'b1, 26'h0000040, 1'b1, 32'h0000_0200, 32'h0000_0200);

        // Branch forward: 0x204 + 0x40 = 0x244.
        do_instr("br_fwd", 1'b1, 32'h0000_0010, 1'b0, 26'd0, 1'b0, 32'd0, 32'h0000_0244);

        // Jump keeps the upper nibble of PC+4.
        do_instr("jr_to_f", 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'hF000_0000, 32'hF000_0000);
        do_instr("jump_hi", 1'b0, 32'd0, 1'b1, 26'h3FF_FFFF, 1'b0, 32'd0, 32'hFFFF_FFFC);

        // PC wrap-around from 0xFFFF_FFFC.
        check("wrap_plus4", pc_plus4, 32'd0);
        do_instr("pc_wrap", 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, 32'd0);

        // Memory wait (3 cycles) then 2 stall cycles.
        req_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (imem_req) req_cnt++;
            imem_ack = (i == 3);
            tick();
        end
        check("wait_req_cycles", 32'(req_cnt), 32'd4);
        check("wait_req_low", {31'd0, imem_req}, 32'd0);
        valid_cnt = 0;
        instr_steady = 1'b1;
        held_ret = retired;
        for (int i = 0; i < 3; i++) begin
            if (instr_valid) valid_cnt++;
            if (instr_out !== mem_word(exp_pc)) instr_steady = 1'b0;
            stall = (i < 2);
            // Controls during a stall must be ignored.
            jr      = (i < 2);
            jr_addr = 32'h0000_0202;
            if (i == 1) check("stall_retired_hold", retired, held_ret);
            if (i == 1) check("stall_pc_hold", pc_out, exp_pc);
            tick();
            clear_ctl();
        end
        exp_pc = 32'd4;
        exp_retired = exp_retired + 32'd1;
        check("stall_valid_cycles", 32'(valid_cnt), 32'd3);
        check("stall_instr_steady", {31'd0, instr_steady}, 32'd1);
        check("stall_retired", retired, exp_retired);
        check("stall_pc", pc_out, exp_pc);
        check("stall_misalign", {31'd0, misalign}, 32'd0);

        // Misaligned JR traps.
        held_pc  = pc_out;
        held_ret = retired;
        imem_ack = 1'b1;
        tick();
        jr = 1'b1;
        jr_addr = 32'h0000_0202;
        tick();
        clear_ctl();
        check("trap_misalign", {31'd0, misalign}, 32'd1);
        check("trap_state", {30'd0, state_dbg}, {30'd0, ST_TRAP});
        req_cnt = 0;
        valid_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req) req_cnt++;
            if (instr_valid) valid_cnt++;
            tick();
        end
        check("trap_req_low", 32'(req_cnt), 32'd0);
        check("trap_valid_low", 32'(valid_cnt), 32'd0);
        check("trap_pc", pc_out, held_pc);
        check("trap_retired", retired, held_ret);
        check("trap_sticky", {31'd0, misalign}, 32'd1);

        // Reset exits the trap.
        do_reset();
        check("clr_state", {30'd0, state_dbg}, {30'd0, ST_BOOT});
        check("clr_misalign", {31'd0, misalign}, 32'd0);
        check("clr_pc", pc_out, 32'd0);
        check("clr_retired", retired, 32'd0);

        // Reset mid-EXEC abandons the instruction.
        tick();
        imem_ack = 1'b1;
        tick();
        check("midexec_state", {30'd0, state_dbg}, {30'd0, ST_EXEC});
        jump = 1'b1;
        jump_index = 26'h0000100;
        do_reset();
        clear_ctl();
        check("midexec_pc", pc_out, 32'd0);
        check("midexec_retired", retired, 32'd0);
        check("midexec_valid", {31'd0, instr_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
